// File: rtl/cordic_engine.sv
// cordic_engine: fully pipelined CORDIC, per-sample vectoring (cartesian->polar)
// or rotation (polar->cartesian). Guard bits widen the datapath, an optional
// 1/K stage removes the CORDIC gain, outputs saturate with an overflow flag,
// and one global enable gives AXI-stream style backpressure.
module cordic_engine #(
  parameter int WIDTH     = 16,
  parameter int STAGES    = 16,
  parameter int GUARD     = 3,
  parameter int GAIN_COMP = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_mode,
  input  logic [2*WIDTH-1:0] s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_mode,
  output logic [2*WIDTH-1:0] m_data,
  output logic               m_ovf
);

  localparam int XW = WIDTH + GUARD + 2;   // x/y: guard bits plus growth for sqrt2*K
  localparam int ZW = WIDTH + GUARD;       // angle: full scale 2^ZW = 2*pi
  localparam int PW = XW + WIDTH + 2;      // gain product width
  localparam real PI = 3.14159265358979323846;

  localparam logic signed [ZW-1:0]    Z_HALF_PI  = {2'b01, {(ZW-2){1'b0}}};
  localparam logic signed [WIDTH-1:0] PH_HALF_PI = {2'b01, {(WIDTH-2){1'b0}}};
  localparam logic signed [XW:0]      X_RND   = {{XW{1'b0}}, 1'b1} << (GUARD - 1);
  localparam logic signed [ZW-1:0]    Z_RND   = {{(ZW-1){1'b0}}, 1'b1} << (GUARD - 1);
  localparam logic signed [XW:0]      SAT_MAX = {{(XW-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [XW:0]      SAT_MIN = {{(XW-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

  // atan(2^-n) scaled so that pi = 2^(ZW-1), rounded to nearest
  function automatic logic [ZW-1:0] atan_entry(input int n);
    real a;
    a = $atan(2.0 ** (-n)) * (2.0 ** (ZW - 1)) / PI;
    return ZW'($rtoi(a + 0.5));
  endfunction

  // round(2^(WIDTH+1)/K), K = prod sqrt(1+2^-2n) over the implemented stages
  function automatic logic [WIDTH+1:0] gain_entry();
    real k;
    k = 1.0;
    for (int n = 0; n < STAGES; n++) begin
      k = k * $sqrt(1.0 + 2.0 ** (-2 * n));
    end
    return (WIDTH+2)'($rtoi((2.0 ** (WIDTH + 1)) / k + 0.5));
  endfunction

  // clip to WIDTH bits; msb of the result flags a clip
  function automatic logic [WIDTH:0] sat_fn(input logic signed [XW:0] v);
    logic [WIDTH:0] r;
    if (v > SAT_MAX)      r = {1'b1, SAT_MAX[WIDTH-1:0]};
    else if (v < SAT_MIN) r = {1'b1, SAT_MIN[WIDTH-1:0]};
    else                  r = {1'b0, v[WIDTH-1:0]};
    return r;
  endfunction

  logic en_s;
  logic m_valid_q, m_mode_q, m_ovf_q;
  logic [2*WIDTH-1:0] m_data_q;

  assign en_s    = !m_valid_q || m_ready;
  assign s_ready = en_s;
  assign m_valid = m_valid_q;
  assign m_mode  = m_mode_q;
  assign m_data  = m_data_q;
  assign m_ovf   = m_ovf_q;

  // stage arrays: index 0 is the quadrant fold, index n+1 follows micro-rotation n
  logic signed [XW-1:0] x_q [STAGES+1];
  logic signed [XW-1:0] y_q [STAGES+1];
  logic signed [ZW-1:0] z_q [STAGES+1];
  logic                 mode_q  [STAGES+1];
  logic                 valid_q [STAGES+1];

  logic signed [WIDTH-1:0] in_lo_s, in_hi_s;
  logic signed [XW-1:0]    lo_ext_s, hi_ext_s, x0_d, y0_d;
  logic signed [ZW-1:0]    ph_ext_s, z0_d;

  assign in_lo_s  = s_data[WIDTH-1:0];
  assign in_hi_s  = s_data[2*WIDTH-1:WIDTH];
  assign lo_ext_s = XW'(in_lo_s) <<< GUARD;
  assign hi_ext_s = XW'(in_hi_s) <<< GUARD;
  assign ph_ext_s = ZW'(in_hi_s) <<< GUARD;

  // exact quadrant fold so the micro-rotations only cover +-pi/2
  always_comb begin
    x0_d = lo_ext_s;
    y0_d = hi_ext_s;
    z0_d = {ZW{1'b0}};
    if (!s_mode) begin
      if (in_lo_s[WIDTH-1] && !in_hi_s[WIDTH-1]) begin
        x0_d = hi_ext_s;
        y0_d = -lo_ext_s;
        z0_d = Z_HALF_PI;
      end else if (in_lo_s[WIDTH-1] && in_hi_s[WIDTH-1]) begin
        x0_d = -hi_ext_s;
        y0_d = lo_ext_s;
        z0_d = -Z_HALF_PI;
      end else begin
        x0_d = lo_ext_s;
        y0_d = hi_ext_s;
        z0_d = {ZW{1'b0}};
      end
    end else begin
      if (in_hi_s > PH_HALF_PI) begin
        x0_d = {XW{1'b0}};
        y0_d = lo_ext_s;
        z0_d = ph_ext_s - Z_HALF_PI;
      end else if (in_hi_s < -PH_HALF_PI) begin
        x0_d = {XW{1'b0}};
        y0_d = -lo_ext_s;
        z0_d = ph_ext_s + Z_HALF_PI;
      end else begin
        x0_d = lo_ext_s;
        y0_d = {XW{1'b0}};
        z0_d = ph_ext_s;
      end
    end
  end

  // fold stage data register (not reset)
  always_ff @(posedge clk) begin
    if (en_s) begin
      x_q[0]    <= x0_d;
      y_q[0]    <= y0_d;
      z_q[0]    <= z0_d;
      mode_q[0] <= s_mode;
    end
  end

  // fold stage valid: a sample enters when s_valid meets s_ready
  always_ff @(posedge clk) begin
    if (reset)     valid_q[0] <= 1'b0;
    else if (en_s) valid_q[0] <= s_valid;
  end

  for (genvar n = 0; n < STAGES; n++) begin : g_stage
    localparam logic signed [ZW-1:0] ATAN_N = atan_entry(n);
    logic                 d_pos_s;
    logic signed [XW-1:0] x_d, y_d;
    logic signed [ZW-1:0] z_d;

    // micro-rotation n: vectoring drives y to 0, rotation drives z to 0
    always_comb begin
      d_pos_s = mode_q[n] ? !z_q[n][ZW-1] : y_q[n][XW-1];
      if (d_pos_s) begin
        x_d = x_q[n] - (y_q[n] >>> n);
        y_d = y_q[n] + (x_q[n] >>> n);
        z_d = z_q[n] - ATAN_N;
      end else begin
        x_d = x_q[n] + (y_q[n] >>> n);
        y_d = y_q[n] - (x_q[n] >>> n);
        z_d = z_q[n] + ATAN_N;
      end
    end

    // micro-rotation data register (not reset)
    always_ff @(posedge clk) begin
      if (en_s) begin
        x_q[n+1]    <= x_d;
        y_q[n+1]    <= y_d;
        z_q[n+1]    <= z_d;
        mode_q[n+1] <= mode_q[n];
      end
    end

    // micro-rotation valid bit, bubbles travel as valid=0
    always_ff @(posedge clk) begin
      if (reset)     valid_q[n+1] <= 1'b0;
      else if (en_s) valid_q[n+1] <= valid_q[n];
    end
  end

  logic signed [XW-1:0] px_s, py_s;
  logic signed [ZW-1:0] pz_s;
  logic                 pmode_s, pvalid_s;

  if (GAIN_COMP != 0) begin : g_gain
    localparam logic signed [WIDTH+1:0] GAIN_K = gain_entry();
    logic signed [PW-1:0] prod_x_s, prod_y_s;
    logic signed [XW-1:0] gx_q, gy_q;
    logic signed [ZW-1:0] gz_q;
    logic                 gmode_q, gvalid_q;

    // scale by 1/K in fixed point
    always_comb begin
      prod_x_s = PW'(x_q[STAGES]) * PW'(GAIN_K);
      prod_y_s = PW'(y_q[STAGES]) * PW'(GAIN_K);
    end

    // gain stage data register (not reset)
    always_ff @(posedge clk) begin
      if (en_s) begin
        gx_q    <= XW'(prod_x_s >>> (WIDTH + 1));
        gy_q    <= XW'(prod_y_s >>> (WIDTH + 1));
        gz_q    <= z_q[STAGES];
        gmode_q <= mode_q[STAGES];
      end
    end

    // gain stage valid bit
    always_ff @(posedge clk) begin
      if (reset)     gvalid_q <= 1'b0;
      else if (en_s) gvalid_q <= valid_q[STAGES];
    end

    assign px_s     = gx_q;
    assign py_s     = gy_q;
    assign pz_s     = gz_q;
    assign pmode_s  = gmode_q;
    assign pvalid_s = gvalid_q;
  end else begin : g_nogain
    assign px_s     = x_q[STAGES];
    assign py_s     = y_q[STAGES];
    assign pz_s     = z_q[STAGES];
    assign pmode_s  = mode_q[STAGES];
    assign pvalid_s = valid_q[STAGES];
  end

  logic signed [XW:0]  rx_s, ry_s;
  logic [WIDTH:0]      satx_s, saty_s;
  logic [WIDTH-1:0]    phase_s;
  logic [2*WIDTH-1:0]  out_d;

  // round half-up, drop guard bits, saturate and pick the output pair
  always_comb begin
    rx_s    = ((XW+1)'(px_s) + X_RND) >>> GUARD;
    ry_s    = ((XW+1)'(py_s) + X_RND) >>> GUARD;
    satx_s  = sat_fn(rx_s);
    saty_s  = sat_fn(ry_s);
    phase_s = WIDTH'((pz_s + Z_RND) >>> GUARD);
    if (pmode_s) out_d = {saty_s[WIDTH-1:0], satx_s[WIDTH-1:0]};
    else         out_d = {phase_s, satx_s[WIDTH-1:0]};
  end

  // output data register, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (en_s) begin
      m_data_q <= out_d;
      m_mode_q <= pmode_s;
    end
  end

  // output valid and overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_ovf_q   <= 1'b0;
    end else if (en_s) begin
      m_valid_q <= pvalid_s;
      m_ovf_q   <= satx_s[WIDTH] || (pmode_s && saty_s[WIDTH]);
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
// Scoreboard bench for cordic_engine: stimulus pushes expected results,
// an independent monitor pops and compares on every output transfer.
module tb_cordic_engine;
  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        reset, s_valid, s_ready, s_mode;
  logic        m_valid, m_ready, m_mode, m_ovf;
  logic [31:0] s_data, m_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic mode;
    int   exp_lo;
    int   tol_lo;
    int   exp_hi;
    int   tol_hi;
    logic hi_wrap;
    logic exp_ovf;
    int   pres_cyc;
    logic lat_chk;
    int   id;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  cordic_engine #(.WIDTH(16), .STAGES(16), .GUARD(3), .GAIN_COMP(1)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_mode(s_mode), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_mode(m_mode), .m_data(m_data),
    .m_ovf(m_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int id, input int act, input int exp,
                     input int tol, input bit wrap);
    int diff;
    logic signed [15:0] d16;
    diff = act - exp;
    if (wrap) begin
      d16  = 16'(diff);
      diff = int'(d16);
    end
    if (diff < 0) diff = -diff;
    checks++;
    if (diff > tol) begin
      failures++;
      $display("FAIL %s id=%0d got=%0d expected=%0d tol=%0d", name, id, act, exp, tol);
    end
  endtask

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else          return -$rtoi(0.5 - r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present one sample, record expectation in the cycle it is accepted
  task automatic send(input exp_t e, input int lo, input int hi);
    int waited;
    waited  = 0;
    s_valid = 1'b1;
    s_mode  = e.mode;
    s_data  = {16'(hi), 16'(lo)};
    @(negedge clk);
    while (!s_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout id=%0d got=s_ready_low expected=s_ready_high", e.id);
    end else begin
      e.pres_cyc = cyc;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_vec(input int i, input int q, input int mag, input int tm,
                          input int ph, input int tp, input bit ovf, input bit lat,
                          input int id);
    exp_t e;
    e.mode = 1'b0; e.exp_lo = mag; e.tol_lo = tm; e.exp_hi = ph; e.tol_hi = tp;
    e.hi_wrap = 1'b1; e.exp_ovf = ovf; e.pres_cyc = 0; e.lat_chk = lat; e.id = id;
    send(e, i, q);
  endtask

  task automatic send_rot(input int mag, input int ph, input int ei, input int ti,
                          input int eq, input int tq, input bit lat, input int id);
    exp_t e;
    e.mode = 1'b1; e.exp_lo = ei; e.tol_lo = ti; e.exp_hi = eq; e.tol_hi = tq;
    e.hi_wrap = 1'b0; e.exp_ovf = 1'b0; e.pres_cyc = 0; e.lat_chk = lat; e.id = id;
    send(e, mag, ph);
  endtask

  // floating-point reference for vectoring
  task automatic send_rand_vec(input int id);
    int i, q;
    real ph;
    i = int'($urandom_range(40000, 0)) - 20000;
    q = int'($urandom_range(40000, 0)) - 20000;
    if (i < 4000 && i > -4000 && q < 4000 && q > -4000) i = 8000;
    ph = $atan2(real'(q), real'(i)) * 32768.0 / PI;
    send_vec(i, q, rnd($sqrt(real'(i) * real'(i) + real'(q) * real'(q))), 5,
             rnd(ph), 3, 1'b0, 1'b0, id);
  endtask

  // floating-point reference for rotation
  task automatic send_rand_rot(input int id);
    int mag, ph;
    real a;
    mag = int'($urandom_range(30000, 4000));
    ph  = int'($urandom_range(65535, 0)) - 32768;
    a   = real'(ph) * PI / 32768.0;
    send_rot(mag, ph, rnd(real'(mag) * $cos(a)), 5, rnd(real'(mag) * $sin(a)), 5,
             1'b0, id);
  endtask

  task automatic wait_drain(input int budget);
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < budget) begin
      tick();
      w++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got=%0d_pending expected=0_pending", sb_q.size());
    end
  endtask

  // monitor: compare every output transfer against the scoreboard head
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output got=%h expected=no_output", m_data);
      end else begin
        mon_e = sb_q.pop_front();
        chk("mode", mon_e.id, int'(m_mode), int'(mon_e.mode), 0, 1'b0);
        chk("lo", mon_e.id, int'($signed(m_data[15:0])), mon_e.exp_lo, mon_e.tol_lo, 1'b0);
        chk("hi", mon_e.id, int'($signed(m_data[31:16])), mon_e.exp_hi, mon_e.tol_hi,
            mon_e.hi_wrap);
        chk("ovf", mon_e.id, int'(m_ovf), int'(mon_e.exp_ovf), 0, 1'b0);
        if (mon_e.lat_chk) chk("latency", mon_e.id, cyc - mon_e.pres_cyc, 19, 0, 1'b0);
      end
    end
  end

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_mode  = 1'b0;
    s_data  = 32'h0;
    m_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", 0, int'(m_valid), 0, 0, 1'b0);
    chk("rst_m_ovf", 0, int'(m_ovf), 0, 0, 1'b0);
    chk("rst_s_ready", 0, int'(s_ready), 1, 0, 1'b0);
    tick();

    // basic vectoring with latency
    send_vec(16384, 0, 16384, 4, 0, 2, 1'b0, 1'b1, 1);
    wait_drain(60);

    // pi/2 and pi (wrap)
    send_vec(0, 16384, 16384, 4, 16384, 2, 1'b0, 1'b0, 2);
    send_vec(-16384, 0, 16384, 4, 32768, 2, 1'b0, 1'b0, 3);
    wait_drain(60);

    // interleaved modes back-to-back
    send_vec(16384, 0, 16384, 4, 0, 2, 1'b0, 1'b0, 4);
    send_rot(16384, 8192, 11585, 4, 11585, 4, 1'b0, 5);
    send_vec(0, 16384, 16384, 4, 16384, 2, 1'b0, 1'b0, 6);
    send_rot(16384, -24576, -11585, 4, -11585, 4, 1'b0, 7);
    wait_drain(60);

    // saturation then clean sample
    send_vec(32767, 32767, 32767, 0, 8192, 2, 1'b1, 1'b0, 8);
    send_vec(100, 0, 100, 4, 0, 64, 1'b0, 1'b0, 9);
    wait_drain(60);

    // random stream with a consumer stall
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(2, 0)) tick();
          if ($urandom_range(1, 0) == 1) send_rand_vec(100 + k);
          else                           send_rand_rot(100 + k);
        end
      end
      begin
        logic [31:0] held;
        int w;
        repeat (30) tick();
        m_ready = 1'b0;
        w = 0;
        @(negedge clk);
        while (!m_valid && w < 100) begin
          @(negedge clk);
          w++;
        end
        chk("stall_m_valid", 0, int'(m_valid), 1, 0, 1'b0);
        held = m_data;
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          chk("stall_s_ready", k, int'(s_ready), 0, 0, 1'b0);
          checks++;
          if (m_data !== held) begin
            failures++;
            $display("FAIL stall_m_data k=%0d got=%h expected=%h", k, m_data, held);
          end
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    wait_drain(200);

    // reset with samples in flight
    for (int k = 0; k < 10; k++) send_rand_vec(300 + k);
    reset = 1'b1;
    sb_q.delete();
    tick();
    chk("reset_m_valid", 0, int'(m_valid), 0, 0, 1'b0);
    tick();
    reset = 1'b0;
    repeat (25) tick();
    send_vec(16384, 0, 16384, 4, 0, 2, 1'b0, 1'b1, 400);
    wait_drain(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cordic_engine.md
Name: cordic_engine

Overview:
- Fully pipelined, runtime-selectable CORDIC engine.
  - Vectoring mode: cartesian to polar.
  - Rotation mode: polar to cartesian.
- Adds over the previous vectoring-only block:
  - per-sample mode select
  - fractional guard bits
  - optional gain compensation
  - output saturation with an overflow flag
  - full-pipeline AXI-stream style backpressure
- Sits in the PHY datapath: between correlator/FFT outputs and phase tracking (vectoring), and at NCO/derotation (rotation).

Parameters:
- WIDTH, 16: I/Q/magnitude/phase sample width, two's complement.
- STAGES, 16: number of micro-rotation stages, range 1..WIDTH.
- GUARD, 3: fractional guard bits added internally to x, y and z.
- GAIN_COMP, 1: when 1, apply a final 1/K multiply stage (K = prod sqrt(1+2^-2n), n=0..STAGES-1); when 0, outputs carry gain K.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- s_valid  input  1  input sample valid.
- s_ready  output  1  input ready.
- s_mode  input  1  0 = vectoring, 1 = rotation; sampled together with s_data.
- s_data  input  2*WIDTH  vectoring: {q, i}; rotation: {phase, mag}; low half is i or mag.
- m_valid  output  1  output valid.
- m_ready  input  1  output ready.
- m_mode  output  1  mode of the sample on m_data.
- m_data  output  2*WIDTH  vectoring: {phase, mag}; rotation: {q, i}; low half is mag or i.
- m_ovf  output  1  the sample on m_data was saturated.

Behaviour:
- Angle format: full scale 2^WIDTH = 2π. π = 2^(WIDTH-1), π/2 = 2^(WIDTH-2). Angle arithmetic wraps modulo 2π.
- Internal x, y width: WIDTH+GUARD+2 (integer growth for sqrt2·K). z width: WIDTH+GUARD. Inputs are left-shifted by GUARD.
- atan table: round(atan(2^-n)·2^(WIDTH+GUARD-1)/π), n=0..STAGES-1, computed at elaboration.
- Stage 0, quadrant fold (exact, no gain):
  - Vectoring: if i<0 and q>=0: (x,y,z)=(q,-i,+π/2). If i<0 and q<0: (x,y,z)=(-q,i,-π/2). Else (i,q,0).
  - Rotation: x=mag, y=0. If phase > π/2: rotate +π/2, giving (x,y)=(0,mag), z=phase-π/2. If phase < -π/2: (0,-mag), z=phase+π/2. Else z=phase.
- Stage n+1 (n=0..STAGES-1):
  - d=+1 when (vectoring and y<0) or (rotation and z>=0); else d=-1.
  - x'=x-d·(y>>>n), y'=y+d·(x>>>n), z'=z-d·atan[n].
- Gain stage (GAIN_COMP=1 only): x, y multiplied by round(2^(WIDTH+1)/K), then shifted right by WIDTH+1.
- Output stage:
  - Round half-up by adding 2^(GUARD-1), then shift right by GUARD.
  - Saturate x and y to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. m_ovf=1 if either clipped.
  - Vectoring emits {z, x}. Rotation emits {y, x}.
- Latency: STAGES+2+GAIN_COMP cycles from accepted input to m_valid, when never stalled.
- Handshake:
  - Single global enable en = !m_valid || m_ready. All stage registers advance only when en.
  - s_ready = en, combinational.
  - A sample is accepted on s_valid && s_ready.
  - Throughput is one sample per clock.
  - While m_valid && !m_ready: m_data, m_mode, m_ovf and m_valid hold stable, and nothing is accepted or lost.
  - Bubbles propagate as valid=0 slots and are not compressed.
- Per-stage valid and mode bits travel with the data. Samples of different modes may be interleaved back-to-back.
- Reset:
  - All stage valid bits and m_valid clear to 0. m_ovf clears to 0. s_ready=1 the cycle after reset deasserts.
  - Data registers are not reset.
  - Reset mid-stream discards all in-flight samples. No partial sample is emitted.
- Simultaneous accept and emit in the same cycle are both honoured.

Test Plan:
1. WIDTH=16, STAGES=16, GAIN_COMP=1; vectoring, i=16384, q=0 -> mag 16384±4, phase 0±2, m_ovf=0, after exactly 19 cycles.
2. Vectoring, i=0, q=16384 -> phase 16384±2 (π/2). Then i=-16384, q=0 -> phase -32768 or 32767 (±π, wrap) ±2, mag 16384±4.
3. Rotation, mag=16384, phase=8192 (π/4) -> i=11585±4, q=11585±4. Then phase=-24576 (-3π/4) -> i=-11585±4, q=-11585±4. Interleave with scenario 1 back-to-back and check per-sample m_mode ordering.
4. Vectoring, i=q=32767 -> mag saturates to 32767 with m_ovf=1, phase 8192±2. The next sample (i=100, q=0) shows m_ovf=0.
5. Stream 40 random samples with random s_valid, and hold m_ready low for 5 cycles while the pipe is full:
   - s_ready is low and m_data is stable while m_ready is low.
   - Outputs match a reference model in order, with no loss and no duplication.
6. Assert reset with 10 samples in flight -> m_valid=0 the next cycle, no stale output afterwards, and the first post-reset sample emerges after 19 cycles.
